seg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment driver. Time-multiplexes N hex digits onto shared SEG/AN pins.

---
 rtl/seg_pkg.sv | 34 +++
 rtl/seg_hex_decoder.sv | 11 +
 rtl/seg_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and the hex glyph table for the multiplexed 7-segment driver.
package seg_pkg;

  // All segments dark, decimal point included (pins are active-low).
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Number of brightness steps each digit slot is divided into.
  localparam int PWM_STEPS = 8;

  // Active-low glyph for one hex nibble; bit 0 = segment a ... bit 6 = segment g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] glyph;
    unique case (nibble)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble + decimal point to active-low SEG[7:0].
module seg_hex_decoder (
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);
  import seg_pkg::*;

  assign seg = {~dp, hex_to_seg(nibble)};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment driver: frame-synchronous loading, per-digit
// blank/blink/dp, leading-zero suppression and PWM brightness. SEG/AN active-low.
module seg_scan_ctrl #(
  parameter int N_DIGITS        = 4,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLINK_FRAMES    = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic [N_DIGITS-1:0]   blink_in,
  input  logic                  lz_en,
  input  logic [2:0]            bright,
  input  logic                  load,
  output logic                  pending,
  output logic                  frame_tick,
  output logic [7:0]            SEG,
  output logic [N_DIGITS-1:0]   AN
);
  import seg_pkg::*;

  localparam int PW    = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int IW    = $clog2(N_DIGITS);
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SLICE = TICKS_PER_DIGIT / PWM_STEPS;

  localparam logic [PW-1:0] P_LAST     = PW'(TICKS_PER_DIGIT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // One complete display configuration; held both as staging and as active copy.
  typedef struct packed {
    logic [4*N_DIGITS-1:0] dig;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
    logic [N_DIGITS-1:0]   blink;
    logic                  lz;
    logic [2:0]            bright;
  } cfg_t;

  localparam cfg_t CFG_RST = '{dig: '0, dp: '0, blank: '1, blink: '0, lz: 1'b0, bright: 3'd7};

  logic [PW-1:0]       p_q, p_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_on_q, blink_on_d;
  logic                pending_q, pending_d;
  cfg_t                stage_q, stage_d;
  cfg_t                act_q, act_d;
  cfg_t                cfg_in;
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic                frame_wrap;
  logic [N_DIGITS-1:0] lz_mask;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic [7:0]          dec_seg;
  logic                pwm_on;
  logic                dark;

  assign frame_wrap = rst && (p_q == P_LAST) && (idx_q == IDX_LAST);
  assign cfg_in     = '{dig: digits_in, dp: dp_in, blank: blank_in, blink: blink_in,
                        lz: lz_en, bright: bright};

  // Prescaler, digit index and blink phase advance.
  always_comb begin
    p_d         = p_q + PW'(1);
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (p_q == P_LAST) begin
      p_d   = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    if (frame_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Staging/active handshake: new values only reach the display on a frame boundary.
  always_comb begin
    stage_d   = stage_q;
    act_d     = act_q;
    pending_d = pending_q;
    if (load) stage_d = cfg_in;
    if (frame_wrap) begin
      pending_d = 1'b0;
      if (load)           act_d = cfg_in;
      else if (pending_q) act_d = stage_q;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Leading-zero mask: digit i is suppressed when it and every digit above it are zero.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (act_q.dig[4*i +: 4] == 4'h0);
      lz_mask[i] = act_q.lz && zero_run;
    end
  end

  assign cur_nib = act_q.dig[{idx_q, 2'b00} +: 4];

  seg_hex_decoder u_dec (
    .nibble (cur_nib),
    .dp     (act_q.dp[idx_q]),
    .seg    (dec_seg)
  );

  // Pin values for the current slot; the last tick of every slot is forced dark
  // so the pins are blank in the cycle where the index moves on.
  always_comb begin
    pwm_on = (32'(p_q) < (({29'd0, act_q.bright} + 32'd1) * 32'(SLICE))) && (p_q != P_LAST);
    dark   = act_q.blank[idx_q] | (act_q.blink[idx_q] & ~blink_on_q) | lz_mask[idx_q];
    an_d   = '1;
    seg_d  = SEG_OFF;
    if (!dark && pwm_on) begin
      an_d[idx_q] = 1'b0;
      seg_d       = dec_seg;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_q         <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      pending_q   <= 1'b0;
      stage_q     <= CFG_RST;
      act_q       <= CFG_RST;
      seg_q       <= SEG_OFF;
      an_q        <= '1;
    end else begin
      p_q         <= p_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      pending_q   <= pending_d;
      stage_q     <= stage_d;
      act_q       <= act_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = frame_wrap;
  assign SEG        = seg_q;
  assign AN         = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, 8 ticks per slot, 2-frame blink).
module tb_seg_scan_ctrl;
  localparam int N   = 4;
  localparam int TPD = 8;
  localparam int BF  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0, blank_in = '0, blink_in = '0;
  logic        lz_en = 1'b0;
  logic [2:0]  bright = 3'd7;
  logic        load = 1'b0;
  logic        pending, frame_tick;
  logic [7:0]  SEG;
  logic [3:0]  AN;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;
  exp_t exp_q[$];

  seg_scan_ctrl #(.N_DIGITS(N), .TICKS_PER_DIGIT(TPD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
    .blink_in(blink_in), .lz_en(lz_en), .bright(bright), .load(load),
    .pending(pending), .frame_tick(frame_tick), .SEG(SEG), .AN(AN)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one load strobe starting at a negedge; returns on the following negedge.
  task automatic do_load(input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] bl,
                         input logic [3:0] bk, input logic lz, input logic [2:0] br);
    digits_in = dig; dp_in = dp; blank_in = bl; blink_in = bk; lz_en = lz; bright = br;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Advance negedge by negedge until frame_tick is seen (bounded).
  task automatic wait_tick(input bit chk_pend, input string tag);
    int n = 0;
    while (frame_tick !== 1'b1 && n < 200) begin
      if (chk_pend) chk({tag, "_pend"}, 32'(pending), 32'd1);
      @(negedge clk);
      n++;
    end
    chk({tag, "_tick"}, 32'(frame_tick), 32'd1);
  endtask

  // Called at a negedge where frame_tick=1: predict and check the next 32 pin samples.
  task automatic run_frame(input logic [31:0] segs, input logic [3:0] lit,
                           input int br, input string tag);
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      int s, q;
      logic on;
      s = k / 8;
      q = k % 8;
      on = lit[s] && (q >= 1) && (q <= br + 1);
      e.an  = on ? ~(4'b0001 << s) : 4'hF;
      e.seg = on ? segs[8*s +: 8] : 8'hFF;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      load = 1'b0;
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d]", tag, k), 32'({AN, SEG}), 32'({e.an, e.seg}));
    end
  endtask

  initial begin
    // 1. reset and idle dark display
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(SEG), 32'hFF);
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    rst = 1'b1;
    wait_tick(1'b0, "t1");
    repeat (4) run_frame(32'hFFFFFFFF, 4'b0000, 7, "t1_dark");
    chk("t1_pend", 32'(pending), 32'd0);

    // 2. basic load and scan order
    @(negedge clk);
    do_load(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 3'd7);
    wait_tick(1'b1, "t2");
    run_frame(32'hF9A4888E, 4'hF, 7, "t2");
    chk("t2_pend_clr", 32'(pending), 32'd0);

    // 3. leading-zero suppression
    @(negedge clk);
    do_load(16'h0030, 4'h0, 4'h0, 4'h0, 1'b1, 3'd7);
    wait_tick(1'b0, "t3a");
    run_frame(32'hFFFFB0C0, 4'b0011, 7, "t3a");
    @(negedge clk);
    do_load(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, 3'd7);
    wait_tick(1'b0, "t3b");
    run_frame(32'hFFFFFFC0, 4'b0001, 7, "t3b");

    // 4. latest load wins; load in the boundary cycle goes straight to active
    @(negedge clk);
    do_load(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0, 3'd7);
    repeat (3) @(negedge clk);
    chk("t4_pend_1111", 32'(pending), 32'd1);
    do_load(16'h2222, 4'h0, 4'h0, 4'h0, 1'b0, 3'd7);
    wait_tick(1'b1, "t4");
    run_frame(32'hA4A4A4A4, 4'hF, 7, "t4_2222");
    chk("t4_at_tick", 32'(frame_tick), 32'd1);
    digits_in = 16'h3333; dp_in = '0; blank_in = '0; blink_in = '0; lz_en = 1'b0; bright = 3'd7;
    load = 1'b1;
    run_frame(32'hB0B0B0B0, 4'hF, 7, "t4_3333");
    chk("t4_pend_3333", 32'(pending), 32'd0);

    // 5. brightness and decimal point
    @(negedge clk);
    do_load(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    wait_tick(1'b0, "t5b0");
    run_frame(32'hF9A4888E, 4'hF, 0, "t5_b0");
    @(negedge clk);
    do_load(16'h12AF, 4'b0010, 4'h0, 4'h0, 1'b0, 3'd3);
    wait_tick(1'b0, "t5b3");
    run_frame(32'hF9A4088E, 4'hF, 3, "t5_b3");

    // 6. mid-slot reset, then blink on digit 2
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_seg", 32'(SEG), 32'hFF);
    chk("t6_rst_an", 32'(AN), 32'hF);
    chk("t6_rst_pend", 32'(pending), 32'd0);
    chk("t6_rst_tick", 32'(frame_tick), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t6_blank[%0d]", i), 32'({AN, SEG}), 32'hFFF);
    end
    do_load(16'h12AF, 4'h0, 4'h0, 4'b0100, 1'b0, 3'd7);
    wait_tick(1'b1, "t6");
    run_frame(32'hF9A4888E, 4'hF,    7, "t6_f1");
    run_frame(32'hF9A4888E, 4'b1011, 7, "t6_f2");
    run_frame(32'hF9A4888E, 4'b1011, 7, "t6_f3");
    run_frame(32'hF9A4888E, 4'hF,    7, "t6_f4");
    run_frame(32'hF9A4888E, 4'hF,    7, "t6_f5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
